// File: rtl/bram_rmw_arbiter_if.sv
// Requester-side bundle for bram_rmw_arbiter:
// update and drain handshakes plus the drain response.
interface bram_rmw_arbiter_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 10
);
  logic                  upd_valid;
  logic                  upd_ready;
  logic [ADDR_WIDTH-1:0] upd_addr;
  logic [DATA_WIDTH-1:0] upd_delta;
  logic                  drn_valid;
  logic                  drn_ready;
  logic [ADDR_WIDTH-1:0] drn_addr;
  logic                  rsp_valid;
  logic [ADDR_WIDTH-1:0] rsp_addr;
  logic [DATA_WIDTH-1:0] rsp_data;

  modport master (
    output upd_valid, upd_addr, upd_delta,
    input  upd_ready,
    output drn_valid, drn_addr,
    input  drn_ready,
    input  rsp_valid, rsp_addr, rsp_data
  );

  modport slave (
    input  upd_valid, upd_addr, upd_delta,
    output upd_ready,
    input  drn_valid, drn_addr,
    output drn_ready,
    output rsp_valid, rsp_addr, rsp_data
  );
endinterface

// File: rtl/bram_rmw_arbiter.sv
// RMW controller/arbiter for one dp_bram: 3-stage pipe,
// forwarding, zero sweep. Macro RMW_SAT_EN: saturating adds.
module bram_rmw_arbiter #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  bram_rmw_arbiter_if.slave     req,
  input  logic                  clr_start,
  output logic                  clr_done,
  output logic                  busy,
  output logic                  bram_en_a,
  output logic                  bram_we_a,
  output logic [ADDR_WIDTH-1:0] bram_addr_a,
  input  logic [DATA_WIDTH-1:0] bram_dout_a,
  output logic                  bram_en_b,
  output logic                  bram_we_b,
  output logic [ADDR_WIDTH-1:0] bram_addr_b,
  output logic [DATA_WIDTH-1:0] bram_din_b
);

  localparam int DW = DATA_WIDTH;
  localparam int AW = ADDR_WIDTH;

  typedef enum logic [1:0] {
    RUN,
    FLUSH,
    CLEAR
  } state_t;

  typedef struct packed {
    logic          v;
    logic          drn;
    logic [AW-1:0] addr;
    logic [DW-1:0] delta;
  } s1_t;

  state_t        state, state_n;
  s1_t           s1;
  logic          s2_v;
  logic          w_v;
  logic [AW-1:0] w_addr;
  logic [DW-1:0] w_data;
  logic [AW-1:0] clr_cnt;
  logic          rr_upd;
  logic          rsp_v;
  logic [AW-1:0] rsp_a;
  logic [DW-1:0] rsp_d;

  logic          run;
  logic          g_upd;
  logic          g_drn;
  logic          acc;
  logic          last;
  logic          clr_wr;
  logic [AW-1:0] clr_addr;
  logic [DW-1:0] opnd;
  logic [DW-1:0] upd_res;
  logic [DW-1:0] nval;

  // Grant: round-robin on contention, none outside RUN
  always_comb begin
    run   = (state == RUN) && !clr_start;
    g_upd = run && req.upd_valid &&
            (!req.drn_valid || rr_upd);
    g_drn = run && req.drn_valid && !g_upd;
    acc   = g_upd || g_drn;
  end

  assign req.upd_ready = g_upd;
  assign req.drn_ready = g_drn;
  assign bram_en_a     = acc;
  assign bram_we_a     = 1'b0;
  assign bram_addr_a   = g_upd ? req.upd_addr :
                         g_drn ? req.drn_addr : '0;

  assign req.rsp_valid = rsp_v;
  assign req.rsp_addr  = rsp_a;
  assign req.rsp_data  = rsp_d;

  assign busy = (state != RUN) || s1.v || s2_v;
  assign last = &clr_cnt;

  // S1 operand: youngest in-flight write wins
  always_comb begin
    opnd = bram_dout_a;
    if (s2_v && bram_addr_b == s1.addr)
      opnd = bram_din_b;
    else if (w_v && w_addr == s1.addr)
      opnd = w_data;
  end

`ifdef RMW_SAT_EN
  logic [DW:0] sum;

  // Saturating add: clamp when sign of the carry differs
  always_comb begin
    sum = {opnd[DW-1], opnd} +
          {s1.delta[DW-1], s1.delta};
    upd_res = sum[DW-1:0];
    if (sum[DW] != sum[DW-1])
      upd_res = sum[DW] ? {1'b1, {(DW-1){1'b0}}}
                        : {1'b0, {(DW-1){1'b1}}};
  end
`else
  // Wrapping add
  always_comb begin
    upd_res = opnd + s1.delta;
  end
`endif

  assign nval = s1.drn ? '0 : upd_res;

  // Controller next state
  always_comb begin
    state_n = state;
    unique case (state)
      RUN:     if (clr_start) state_n = FLUSH;
      FLUSH:   if (!s1.v && !s2_v) state_n = CLEAR;
      CLEAR:   if (last) state_n = RUN;
      default: state_n = RUN;
    endcase
  end

  // Sweep write issue: addr 0 on entry, then one per cycle
  always_comb begin
    clr_wr   = 1'b0;
    clr_addr = '0;
    unique case (1'b1)
      (state == FLUSH): clr_wr = (state_n == CLEAR);
      (state == CLEAR): begin
        clr_wr   = !last;
        clr_addr = clr_cnt + 1'b1;
      end
      default: clr_wr = 1'b0;
    endcase
  end

  // FSM, arbitration pointer and sweep counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= RUN;
      rr_upd   <= 1'b1;
      clr_cnt  <= '0;
      clr_done <= 1'b0;
    end else begin
      state    <= state_n;
      clr_done <= (state == CLEAR) && last;
      if (state == CLEAR) clr_cnt <= clr_cnt + 1'b1;
      else                clr_cnt <= '0;
      if (acc) rr_upd <= g_drn;
    end
  end

  // S1 capture of the accepted request
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= '0;
    end else begin
      s1.v     <= acc;
      s1.drn   <= g_drn;
      s1.addr  <= bram_addr_a;
      s1.delta <= req.upd_delta;
    end
  end

  // S2: port-B write, drain response, last-write reg
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_v        <= 1'b0;
      bram_en_b   <= 1'b0;
      bram_we_b   <= 1'b0;
      bram_addr_b <= '0;
      bram_din_b  <= '0;
      rsp_v       <= 1'b0;
      rsp_a       <= '0;
      rsp_d       <= '0;
      w_v         <= 1'b0;
      w_addr      <= '0;
      w_data      <= '0;
    end else begin
      s2_v   <= s1.v;
      w_v    <= bram_en_b;
      w_addr <= bram_addr_b;
      w_data <= bram_din_b;
      rsp_v  <= s1.v && s1.drn;
      if (s1.v && s1.drn) begin
        rsp_a <= s1.addr;
        rsp_d <= opnd;
      end
      if (clr_wr) begin
        bram_en_b   <= 1'b1;
        bram_we_b   <= 1'b1;
        bram_addr_b <= clr_addr;
        bram_din_b  <= '0;
      end else begin
        bram_en_b <= s1.v;
        bram_we_b <= s1.v;
        if (s1.v) begin
          bram_addr_b <= s1.addr;
          bram_din_b  <= nval;
        end
      end
    end
  end

endmodule

// File: doc/bram_rmw_arbiter.md
# bram_rmw_arbiter

Read-modify-write controller and arbiter in front of one `dp_bram` instance in the convolution path. Two requesters share it:
- an update stream that adds a signed delta to a stored word;
- a drain stream that returns a stored word and zeroes it.

Port A is used only for reads and port B only for writes. A 3-stage pipeline with forwarding sustains one operation per cycle, including back-to-back hits on the same address. A sweep mode clears the whole memory.

## Interface
- `DATA_WIDTH`, 16: stored word width; words and deltas are signed two's complement.
- `ADDR_WIDTH`, 10: BRAM address width; depth is 2**ADDR_WIDTH.
- `clk` in 1: single clock, shared with the BRAM.
- `rst_n` in 1: asynchronous, active-low reset.
- `upd_valid` in 1 / `upd_ready` out 1: update request handshake.
- `upd_addr` in ADDR_WIDTH / `upd_delta` in DATA_WIDTH: target address and signed increment.
- `drn_valid` in 1 / `drn_ready` out 1: drain request handshake.
- `drn_addr` in ADDR_WIDTH: drain address.
- `rsp_valid` out 1: drain response pulse; no backpressure, the consumer must take it.
- `rsp_addr` out ADDR_WIDTH / `rsp_data` out DATA_WIDTH: drained address and its pre-clear value.
- `clr_start` in 1: request a full-memory zero sweep.
- `clr_done` out 1: one-cycle pulse after the last sweep write.
- `busy` out 1: high when not idle or while the pipeline holds work.
- `bram_en_a` out 1, `bram_we_a` out 1 (constant 0), `bram_addr_a` out ADDR_WIDTH, `bram_dout_a` in DATA_WIDTH: port A.
- `bram_en_b` out 1, `bram_we_b` out 1, `bram_addr_b` out ADDR_WIDTH, `bram_din_b` out DATA_WIDTH: port B.
- Each BRAM port maps one-to-one onto the like-named signal of `dp_bram_if`. Port B's data_out is unused.

## Operation
- **FSM states:**
  - `RUN` is the reset state.
  - `RUN`→`FLUSH`: `clr_start` sampled high. All readies go low immediately.
  - `FLUSH`→`CLEAR`: pipeline stages S1 and S2 are both empty.
  - `CLEAR`: drives one port-B write of 0 per cycle. Counter runs 0..2**ADDR_WIDTH-1.
  - `CLEAR`→`RUN`: after the last-address write, `clr_done` pulses once.
  - `clr_start` in any state other than `RUN` is ignored.
- **Arbitration, in `RUN`:**
  - One grant per cycle.
  - Only one requester valid: that requester is granted.
  - Both valid: round-robin. The requester not granted last time wins.
  - Pointer updates only on an accepted transfer.
  - `upd_ready`/`drn_ready` are combinational from the grant and may depend on the other requester's valid.
- **Stage S0 (accept cycle t):**
  - `bram_en_a`=1 and `bram_addr_a`=granted address, driven combinationally.
  - Opcode, address and delta are captured into S1.
- **Stage S1 (t+1):**
  - Operand is selected in priority order:
    1. S2 result, if S2 is valid with the same address;
    2. last-written register W (address/data of the port-B write issued at t), if valid with the same address;
    3. `bram_dout_a`.
  - New value: operand+delta for update, 0 for drain. Registered into S2.
  - For drain, the operand is also registered as the response data.
- **Stage S2 (t+2):**
  - Registered `bram_en_b`=`bram_we_b`=1, `bram_addr_b`, `bram_din_b`.
  - W is loaded with the same address/data.
  - Drain: `rsp_valid`=1 with `rsp_addr`/`rsp_data`.
- **Arithmetic:** a DATA_WIDTH signed add. Overflow handling is set by the `RMW_SAT_EN` macro (see Configuration).
- **Port A/B collision:** port A reads and port B writes to the same address in the same cycle are legal. The forwarding above makes the stale read irrelevant.

## Timing
- **Reset values:**
  - Readies, `bram_en_a`/`bram_en_b`/`bram_we_b`, `rsp_valid`, `clr_done` and `busy`: 0.
  - All address and data outputs: 0.
  - S1, S2 and W valids: 0. Round-robin pointer favours update.
- **Latency:** accept at edge t gives port-B write and `rsp_valid` in cycle t+2. Throughput is 1 operation/cycle.
- **Clear timing:** a sweep takes 2**ADDR_WIDTH cycles plus the flush wait. `clr_done` is asserted in the cycle after the last write.
- **Reset mid-operation:** in-flight operations are discarded with no port-B write; BRAM contents are untouched. A sweep aborts at its current address.
- **`busy`:** high in `FLUSH` and `CLEAR`, and whenever S1 or S2 is valid.

## Configuration
- `RMW_SAT_EN` defined: update results clamp to [-2**(DATA_WIDTH-1), 2**(DATA_WIDTH-1)-1].
- `RMW_SAT_EN` undefined: two's-complement wrap.
- Drain and clear are unaffected by the macro.

## Test plan
- **Single update:** memory[5]=10, update addr 5 delta +3 → port-B write addr 5 data 13 at t+2; `rsp_valid` stays 0.
- **Back-to-back forwarding:** updates to addr 7 with +1 on three consecutive cycles, memory[7]=0 → writes 1, 2, 3 on consecutive cycles.
- **Contention:** `upd_valid` and `drn_valid` held high for 4 cycles → grants alternate update, drain, update, drain.
- **Drain:** memory[9]=-4 → `rsp_data`=-4 at t+2 and port-B write of 0. A later update +2 at addr 9 writes 2.
- **Saturation:** memory[1]=32767, delta +5 → writes 32767 with `RMW_SAT_EN`, -32764 without.
- **Clear:** `clr_start` with 2 operations in flight → both writes complete, then 1024 zero writes, then `clr_done` pulses once. `rst_n` low mid-sweep → all outputs return to reset values next cycle.
